agc_envelope_detector: RTL
==========================

# agc_envelope_detector

Front-end conditioning stage that feeds the automatic gain control core. It takes raw 8-bit offset-binary samples from the input pins and removes their DC offset with a first-order running-mean tracker. It produces the signed centred sample, its magnitude, a peak-hold envelope with timed decay, and a clip flag. The AGC uses the envelope as its level measurement.

## Interface
Parameters:
- DECAY_PERIOD, 256: clock cycles between envelope decay steps; must be ≥ 2.
- DECAY_SHIFT, 4: decay step is envelope >> DECAY_SHIFT, with a minimum step of 1; range 1–7.
- DC_SHIFT, 6: DC tracker time constant, 2^DC_SHIFT samples; range 1–8.

Ports:
- clk, in, 1: the single clock; all state is on its rising edge.
- reset_not, in, 1: asynchronous, active-low reset.
- sample_in, in, 8: unsigned offset-binary sample, with 128 as nominal zero.
- sample_valid, in, 1: sample_in is consumed on every rising clk edge where this is high; there is no backpressure.
- sample_out, out, 8: two's-complement DC-removed sample.
- magnitude, out, 8: unsigned |centred sample|, range 0–128.
- envelope, out, 8: unsigned peak-hold envelope.
- out_valid, out, 1: one-cycle pulse marking new sample_out, magnitude and clip.
- clip, out, 1: the sample carried by out_valid was 0 or 255.

## Operation
- DC accumulator dc_acc: 16 bits, Q8.8; the DC estimate is dc_acc[15:8].
- On each valid sample:
  - Form diff = {sample_in, 8'h00} − dc_acc as a 17-bit signed value.
  - Update dc_acc ← dc_acc + (diff >>> DC_SHIFT), using an arithmetic shift.
  - dc_acc must never wrap; it stays within 0x0000–0xFF00 by construction.
- Centring:
  - centred = sample_in − dc_est, 9-bit signed, computed from the estimate before the update.
  - Saturate centred to [−128, 127] to form sample_out.
  - magnitude = |centred| after saturation, so −128 gives 128.
- Decay counter:
  - Free-running over 0..DECAY_PERIOD−1, advancing every cycle regardless of sample_valid.
  - tick is asserted in the cycle the counter equals DECAY_PERIOD−1; the counter then wraps to 0.
- Envelope update, every cycle:
  - cand = tick ? env − max(1, env >> DECAY_SHIFT) : env.
  - If env = 0, then cand = 0; no underflow is allowed.
  - If sample_valid and new magnitude > cand, then env ← new magnitude; otherwise env ← cand.
  - Attack is therefore immediate; a simultaneous tick is consumed, not deferred.
- clip is set from the raw input (sample_in = 0x00 or 0xFF), independent of the DC estimate.
- Between valid pulses, sample_out, magnitude and clip hold their last values; envelope keeps decaying.

## Timing
- Reset (reset_not low, asynchronous) takes effect immediately and holds while low:
  - dc_acc = 0x8000, decay counter = 0.
  - sample_out = 0, magnitude = 0, envelope = 0, out_valid = 0, clip = 0.
- Latency is 1 cycle: a sample accepted at edge N drives all outputs and out_valid = 1 immediately after edge N, and out_valid drops after edge N+1 unless another sample is accepted.
- Back-to-back valid samples, one per cycle, are sustained with out_valid held high.
- Reset asserted mid-stream discards any in-flight result; the first sample after release uses a DC estimate of 128.
- The first decay tick after reset release occurs DECAY_PERIOD cycles later, counting the cycle in which the counter is 0.

## Test plan
- **Reset:** pulse reset_not low mid-stream, asynchronously between edges. All outputs must go to 0 before the next edge; after release, 128 in gives sample_out 0.
- **Single sample:** after reset, apply 200 valid for one cycle. The next cycle must show sample_out = 72, magnitude = 72, envelope = 72, out_valid = 1 for exactly one cycle, clip = 0.
- **Decay** (DECAY_PERIOD = 4, DECAY_SHIFT = 4, envelope 72, no valid):
  - Envelope must step 72 → 68 → 64 → 60, one step every 4 cycles.
  - From 15 it must step 15 → 14 (minimum step 1), and it must reach and hold 0.
- **Clip/saturation:** from reset, apply 0 → sample_out = −128 (0x80), magnitude = 128, clip = 1. Next apply 255 → clip = 1 and sample_out saturated at ≤ 127.
- **DC tracking** (DC_SHIFT = 6): apply constant 160 valid every cycle. sample_out must fall monotonically from 32 to within ±1 of 0 within 1024 samples, and envelope must hold near 32 until it decays.
- **Tick collision:** align a valid sample with a tick, with envelope = 64 and DECAY_SHIFT = 4, checking both outcomes:
  - Magnitude 62 must give envelope 62, because 62 > 60.
  - Magnitude 10 must give envelope 60.

Source files
------------

// File: rtl/agc_envelope_detector_if.sv
// Sample stream bundle for the AGC envelope detector.
// The master drives raw samples; the slave returns the conditioned results.
interface agc_envelope_detector_if;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [7:0] sample_out;
  logic [7:0] magnitude;
  logic [7:0] envelope;
  logic       out_valid;
  logic       clip;

  modport master (
    output sample_in, sample_valid,
    input  sample_out, magnitude, envelope, out_valid, clip
  );

  modport slave (
    input  sample_in, sample_valid,
    output sample_out, magnitude, envelope, out_valid, clip
  );
endinterface

// File: rtl/agc_envelope_detector.sv
// AGC front end: DC removal by running-mean tracker, saturation, magnitude,
// peak-hold envelope with timed decay and raw-input clip detection.
module agc_envelope_detector #(
  parameter int DECAY_PERIOD = 256,
  parameter int DECAY_SHIFT  = 4,
  parameter int DC_SHIFT     = 6
) (
  input  logic                    clk,
  input  logic                    reset_not,
  agc_envelope_detector_if.slave  bus
);

  localparam int CW = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECAY_PERIOD - 1);
  localparam logic signed [8:0] SAT_HI = 9'sd127;
  localparam logic signed [8:0] SAT_LO = -9'sd128;

  logic [15:0]        dc_acc;
  logic [7:0]         dc_est;
  logic signed [16:0] diff;
  logic signed [16:0] dc_step;
  logic [16:0]        dc_sum;
  logic signed [8:0]  centred;
  logic [7:0]         sat;
  logic [7:0]         mag;
  logic [CW-1:0]      cnt;
  logic               tick;
  logic [7:0]         env;
  logic [7:0]         dec;
  logic [7:0]         dec_step;
  logic [7:0]         cand;
  logic [7:0]         env_next;

  assign dc_est = dc_acc[15:8];

  // Tracker moves a fraction of the error towards the sample; the floor of the
  // shift never overshoots the target, so the Q8.8 accumulator cannot wrap.
  always_comb begin
    diff    = $signed({1'b0, bus.sample_in, 8'h00}) - $signed({1'b0, dc_acc});
    dc_step = diff >>> DC_SHIFT;
    dc_sum  = {1'b0, dc_acc} + $unsigned(dc_step);
  end

  always_comb begin
    centred = $signed({1'b0, bus.sample_in}) - $signed({1'b0, dc_est});
    if (centred > SAT_HI) begin
      sat = 8'h7F;
    end else if (centred < SAT_LO) begin
      sat = 8'h80;
    end else begin
      sat = centred[7:0];
    end
    mag = sat[7] ? (8'd0 - sat) : sat;
  end

  assign tick = (cnt == CNT_LAST);

  // Decay always removes at least one count so small envelopes still reach zero.
  always_comb begin
    dec      = env >> DECAY_SHIFT;
    dec_step = (dec == 8'd0) ? 8'd1 : dec;
    cand     = (tick && env != 8'd0) ? (env - dec_step) : env;
    env_next = (bus.sample_valid && mag > cand) ? mag : cand;
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      dc_acc <= 16'h8000;
    end else if (bus.sample_valid) begin
      dc_acc <= dc_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      bus.sample_out <= 8'h00;
      bus.magnitude  <= 8'h00;
      bus.clip       <= 1'b0;
      bus.out_valid  <= 1'b0;
    end else begin
      bus.out_valid <= bus.sample_valid;
      if (bus.sample_valid) begin
        bus.sample_out <= sat;
        bus.magnitude  <= mag;
        bus.clip       <= (bus.sample_in == 8'h00) || (bus.sample_in == 8'hFF);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      env <= 8'h00;
    end else begin
      env <= env_next;
    end
  end

  assign bus.envelope = env;

endmodule
